mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter OUTSTANDING, default 4: maximum in-flight loads, legal range 1..15.
REQ-002 Parameter XLEN, default 32: address width.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ic_req_valid  in  1  I-side line-fetch request.
REQ-006 ic_req_addr  in  XLEN  I-side fetch address, 8-byte aligned.
REQ-007 ic_req_ready  out  1  I-side request accepted by memory this cycle; combinational.
REQ-008 dc_req_valid  in  1  D-side request.
REQ-009 dc_req_cmd  in  2  request type: 1 = LOAD, 2 = STORE; 0 and 3 are illegal.
REQ-010 dc_req_addr  in  XLEN  D-side address.
REQ-011 dc_req_data  in  64  store data.
REQ-012 dc_req_size  in  2  MEM_SIZE encoding: BYTE/HALF/WORD/DOUBLE.
REQ-013 dc_req_ready  out  1  D-side request accepted this cycle; combinational.
REQ-014 ic_resp_valid / dc_resp_valid  out  1 each  one-cycle load-return pulse per side.
REQ-015 ic_resp_data / dc_resp_data  out  64 each  returned load data; valid only while the matching resp_valid is 1.
REQ-016 proc2mem_command  out  2  bus command: 0 = NONE, 1 = LOAD, 2 = STORE.
REQ-017 proc2mem_addr / proc2mem_data / proc2mem_size  out  XLEN / 64 / 2  bus request fields.
REQ-018 mem2proc_response  in  4  same-cycle accept tag; 0 = rejected.
REQ-019 mem2proc_data / mem2proc_tag  in  64 / 4  load return data and its tag; tag 0 = no return.
REQ-020 outstanding_count  out  4  number of valid tag-table entries.
REQ-021 bus_error  out  1  sticky protocol-violation flag.

Function
REQ-022 Block SHALL hold a tag table of 15 entries (tags 1..15), each entry being {valid, owner = I or D}.
REQ-023 Issue path SHALL be combinational: in each cycle at most one requester is selected, and its fields are driven onto proc2mem_*.
REQ-024 With no selection, proc2mem_command SHALL be 0 and proc2mem_addr/data/size SHALL be 0.
REQ-025 I-side requests SHALL issue as LOAD with size DOUBLE and proc2mem_data 0.
REQ-026 A load (I or D) SHALL be eligible only when outstanding_count < OUTSTANDING; a D-side STORE SHALL always be eligible.
REQ-027 Arbitration: if only one requester is eligible, it SHALL be selected; if both are eligible, the side named by a 1-bit priority pointer SHALL be selected.
REQ-028 The pointer SHALL flip to the other side after every accepted issue made while both sides were eligible.
REQ-029 The selected side's ready SHALL equal (mem2proc_response != 0); a rejected request SHALL produce ready = 0, and the requester retries by holding valid.
REQ-030 On an accepted LOAD, entry[mem2proc_response] SHALL become {valid = 1, owner = selected side} at the next edge. An accepted STORE SHALL allocate no entry.
REQ-031 On a nonzero mem2proc_tag matching a valid entry:
- the owner's resp_valid SHALL pulse 1 on the next cycle;
- the owner's resp_data SHALL be the registered mem2proc_data;
- the entry SHALL be cleared at that edge.
Return latency is therefore 1 cycle.
REQ-032 A nonzero mem2proc_tag matching an invalid entry SHALL set bus_error and SHALL produce no response pulse.
REQ-033 Free and allocate of the same tag in one cycle: the free SHALL be applied first, so the entry ends valid with the new owner and no error.
REQ-034 An allocation to a tag that is still valid and not freed that cycle SHALL set bus_error and overwrite the owner.
REQ-035 dc_req_cmd of 0 or 3 with dc_req_valid = 1 SHALL be ignored (never selected) and SHALL set bus_error.
REQ-036 outstanding_count SHALL equal the popcount of valid entries (registered) and SHALL never exceed OUTSTANDING.
REQ-037 ic_resp_valid and dc_resp_valid SHALL never both be 1 in the same cycle, since at most one tag returns per cycle.

Reset
REQ-038 On reset = 1 at an edge the block SHALL:
- clear all table entries;
- set outstanding_count = 0, bus_error = 0 and both resp_valid = 0;
- set resp_data = 0;
- set the pointer to D-side priority.
REQ-039 While reset = 1, proc2mem_command SHALL be 0 and both ready outputs SHALL be 0.
REQ-040 Loads in flight at reset SHALL be dropped; their later returns count as unmatched per REQ-032.

Verification
REQ-041 Single I fetch to 0x100, memory accepts with tag 3 and returns tag 3 with data 0xDEADBEEF_00000013 five cycles later -> ic_resp_valid for 1 cycle carrying that data; count goes 0 -> 1 -> 0.
REQ-042 Both sides request loads continuously, memory always accepts -> grants alternate D, I, D, I starting with D after reset.
REQ-043 OUTSTANDING = 4, four loads accepted with no returns -> fifth load blocked (ready 0, command 0) while a D store still issues; one return unblocks the next load.
REQ-044 In the same cycle tag 5 returns for D and tag 5 is reissued to I -> dc_resp_valid pulses, entry 5 owner = I, bus_error stays 0.
REQ-045 mem2proc_tag = 9 with entry 9 invalid -> bus_error = 1 and stays 1 until reset, with no resp pulse.
REQ-046 Reset asserted with 2 loads outstanding, then a return for one of those tags -> count = 0 after reset, and bus_error = 1 after the return.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
//   Arbitrates the instruction-cache line-fetch port and the data-cache
//   load/store port onto a single tagged memory bus. Loads are tracked in
//   a 15-entry tag table (tags 1..15) so that returns are routed back to the
//   side that issued them.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   ic_req_*                  I-side fetch request (always LOAD, size DOUBLE)
//   dc_req_*                  D-side request (cmd 1 = LOAD, 2 = STORE)
//   ic_resp_* / dc_resp_*     registered one-cycle load-return pulses
//   proc2mem_*                combinational bus request fields
//   mem2proc_response         same-cycle accept tag (0 = rejected)
//   mem2proc_data/_tag        load return data and tag (tag 0 = no return)
//   outstanding_count         registered number of valid table entries
//   bus_error                 sticky protocol-violation flag
// ---------------------------------------------------------------------------
module mem_bus_ctrl #(
  parameter int OUTSTANDING = 4,
  parameter int XLEN        = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ic_req_valid,
  input  logic [XLEN-1:0] ic_req_addr,
  output logic            ic_req_ready,
  input  logic            dc_req_valid,
  input  logic [1:0]      dc_req_cmd,
  input  logic [XLEN-1:0] dc_req_addr,
  input  logic [63:0]     dc_req_data,
  input  logic [1:0]      dc_req_size,
  output logic            dc_req_ready,
  output logic            ic_resp_valid,
  output logic [63:0]     ic_resp_data,
  output logic            dc_resp_valid,
  output logic [63:0]     dc_resp_data,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [1:0]      proc2mem_size,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [3:0]      outstanding_count,
  output logic            bus_error
);

  localparam logic [1:0] CMD_NONE    = 2'd0;
  localparam logic [1:0] CMD_LOAD    = 2'd1;
  localparam logic [1:0] CMD_STORE   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;
  localparam logic       OWNER_I     = 1'b0;
  localparam logic       OWNER_D     = 1'b1;
  localparam logic [3:0] MAX_OUT     = 4'(OUTSTANDING);

  // Count of set bits; bit 0 is never set because tag 0 is never allocated.
  function automatic logic [3:0] popcount16(input logic [15:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 1; i < 16; i++) begin
      sum = sum + {3'd0, v[i]};
    end
    return sum;
  endfunction

  // Tag table, indexed directly by tag; entry 0 stays invalid.
  logic [15:0]     valid_r;
  logic [15:0]     owner_r;
  logic            prio_d_r;
  logic [3:0]      count_r;
  logic            bus_error_r;
  logic            ic_resp_valid_r;
  logic            dc_resp_valid_r;
  logic [63:0]     ic_resp_data_r;
  logic [63:0]     dc_resp_data_r;

  logic            dc_load_s;
  logic            dc_store_s;
  logic            dc_illegal_s;
  logic            load_ok_s;
  logic            ic_elig_s;
  logic            dc_elig_s;
  logic            both_elig_s;
  logic            sel_i_s;
  logic            sel_d_s;
  logic            accept_s;
  logic            ret_hit_s;
  logic            ret_miss_s;
  logic            ret_owner_s;
  logic            alloc_s;
  logic            alloc_clash_s;
  logic [15:0]     valid_nxt_s;
  logic [15:0]     owner_nxt_s;

  // Request decode, eligibility and priority arbitration.
  always_comb begin
    dc_load_s    = dc_req_valid && (dc_req_cmd == CMD_LOAD);
    dc_store_s   = dc_req_valid && (dc_req_cmd == CMD_STORE);
    dc_illegal_s = dc_req_valid && ((dc_req_cmd == 2'd0) || (dc_req_cmd == 2'd3));
    load_ok_s    = (count_r < MAX_OUT);
    // Nothing is selected while in reset so the bus stays idle.
    ic_elig_s    = !reset && ic_req_valid && load_ok_s;
    dc_elig_s    = !reset && (dc_store_s || (dc_load_s && load_ok_s));
    both_elig_s  = ic_elig_s && dc_elig_s;
    accept_s     = (mem2proc_response != 4'd0);
    sel_i_s      = 1'b0;
    sel_d_s      = 1'b0;
    if (both_elig_s) begin
      if (prio_d_r) begin
        sel_d_s = 1'b1;
      end else begin
        sel_i_s = 1'b1;
      end
    end else if (ic_elig_s) begin
      sel_i_s = 1'b1;
    end else if (dc_elig_s) begin
      sel_d_s = 1'b1;
    end else begin
      sel_i_s = 1'b0;
    end
  end

  // Bus request mux and per-side ready.
  always_comb begin
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = 64'd0;
    proc2mem_size    = 2'd0;
    if (sel_i_s) begin
      proc2mem_command = CMD_LOAD;
      proc2mem_addr    = ic_req_addr;
      proc2mem_size    = SIZE_DOUBLE;
    end else if (sel_d_s) begin
      proc2mem_command = dc_req_cmd;
      proc2mem_addr    = dc_req_addr;
      proc2mem_data    = dc_req_data;
      proc2mem_size    = dc_req_size;
    end else begin
      proc2mem_command = CMD_NONE;
    end
    ic_req_ready = sel_i_s && accept_s;
    dc_req_ready = sel_d_s && accept_s;
  end

  // Tag table next state: a return frees its entry before any allocation,
  // so a tag freed and reissued in the same cycle is not a clash.
  always_comb begin
    valid_nxt_s   = valid_r;
    owner_nxt_s   = owner_r;
    ret_hit_s     = (mem2proc_tag != 4'd0) && valid_r[mem2proc_tag];
    ret_miss_s    = (mem2proc_tag != 4'd0) && !valid_r[mem2proc_tag];
    ret_owner_s   = owner_r[mem2proc_tag];
    alloc_s       = accept_s && (sel_i_s || (sel_d_s && dc_load_s));
    alloc_clash_s = alloc_s && valid_r[mem2proc_response]
                    && !(ret_hit_s && (mem2proc_tag == mem2proc_response));
    if (ret_hit_s) begin
      valid_nxt_s[mem2proc_tag] = 1'b0;
    end else begin
      valid_nxt_s[0] = 1'b0;
    end
    if (alloc_s) begin
      valid_nxt_s[mem2proc_response] = 1'b1;
      owner_nxt_s[mem2proc_response] = sel_d_s ? OWNER_D : OWNER_I;
    end else begin
      owner_nxt_s[0] = 1'b0;
    end
  end

  // State registers: table, count, priority pointer, error flag, responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r         <= 16'd0;
      owner_r         <= 16'd0;
      count_r         <= 4'd0;
      prio_d_r        <= 1'b1;
      bus_error_r     <= 1'b0;
      ic_resp_valid_r <= 1'b0;
      dc_resp_valid_r <= 1'b0;
      ic_resp_data_r  <= 64'd0;
      dc_resp_data_r  <= 64'd0;
    end else begin
      valid_r         <= valid_nxt_s;
      owner_r         <= owner_nxt_s;
      count_r         <= popcount16(valid_nxt_s);
      prio_d_r        <= (accept_s && both_elig_s) ? ~prio_d_r : prio_d_r;
      bus_error_r     <= bus_error_r | ret_miss_s | alloc_clash_s | dc_illegal_s;
      ic_resp_valid_r <= ret_hit_s && (ret_owner_s == OWNER_I);
      dc_resp_valid_r <= ret_hit_s && (ret_owner_s == OWNER_D);
      ic_resp_data_r  <= (ret_hit_s && (ret_owner_s == OWNER_I)) ? mem2proc_data : 64'd0;
      dc_resp_data_r  <= (ret_hit_s && (ret_owner_s == OWNER_D)) ? mem2proc_data : 64'd0;
    end
  end

  assign outstanding_count = count_r;
  assign bus_error         = bus_error_r;
  assign ic_resp_valid     = ic_resp_valid_r;
  assign dc_resp_valid     = dc_resp_valid_r;
  assign ic_resp_data      = ic_resp_data_r;
  assign dc_resp_data      = dc_resp_data_r;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_ctrl
//   Directed bench for mem_bus_ctrl (OUTSTANDING = 4, XLEN = 32). Inputs are
//   driven 1 time unit after each rising edge; combinational outputs are
//   checked just before the next edge, registered outputs after it.
// ---------------------------------------------------------------------------
module tb_mem_bus_ctrl;

  logic        clock;
  logic        reset;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        dc_req_valid;
  logic [1:0]  dc_req_cmd;
  logic [31:0] dc_req_addr;
  logic [63:0] dc_req_data;
  logic [1:0]  dc_req_size;
  logic        dc_req_ready;
  logic        ic_resp_valid;
  logic [63:0] ic_resp_data;
  logic        dc_resp_valid;
  logic [63:0] dc_resp_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [1:0]  proc2mem_size;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [3:0]  outstanding_count;
  logic        bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_ctrl #(.OUTSTANDING(4), .XLEN(32)) dut (
    .clock             (clock),
    .reset             (reset),
    .ic_req_valid      (ic_req_valid),
    .ic_req_addr       (ic_req_addr),
    .ic_req_ready      (ic_req_ready),
    .dc_req_valid      (dc_req_valid),
    .dc_req_cmd        (dc_req_cmd),
    .dc_req_addr       (dc_req_addr),
    .dc_req_data       (dc_req_data),
    .dc_req_size       (dc_req_size),
    .dc_req_ready      (dc_req_ready),
    .ic_resp_valid     (ic_resp_valid),
    .ic_resp_data      (ic_resp_data),
    .dc_resp_valid     (dc_resp_valid),
    .dc_resp_data      (dc_resp_data),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .proc2mem_size     (proc2mem_size),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .outstanding_count (outstanding_count),
    .bus_error         (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs may be changed right after return.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_valid      = 1'b0;
    dc_req_valid      = 1'b0;
    dc_req_cmd        = 2'd0;
    mem2proc_response = 4'd0;
    mem2proc_tag      = 4'd0;
    mem2proc_data     = 64'd0;
  endtask

  initial begin
    reset        = 1'b1;
    ic_req_addr  = 32'h0000_0100;
    dc_req_addr  = 32'h0000_0200;
    dc_req_data  = 64'd0;
    dc_req_size  = 2'd3;
    idle_inputs();

    // While in reset, requests and accept tags must not leak onto the bus.
    ic_req_valid      = 1'b1;
    dc_req_valid      = 1'b1;
    dc_req_cmd        = 2'd1;
    mem2proc_response = 4'd1;
    #2;
    chk("rst_ic_ready", ic_req_ready, 1'b0);
    chk("rst_dc_ready", dc_req_ready, 1'b0);
    chk("rst_cmd", proc2mem_command, 2'd0);
    tick();
    tick();
    idle_inputs();
    chk("rst_count", outstanding_count, 4'd0);
    chk("rst_err", bus_error, 1'b0);
    chk("rst_icv", ic_resp_valid, 1'b0);
    chk("rst_dcv", dc_resp_valid, 1'b0);
    chk("rst_dcdata", dc_resp_data, 64'd0);
    reset = 1'b0;
    #1;
    chk("idle_cmd", proc2mem_command, 2'd0);
    chk("idle_addr", proc2mem_addr, 32'd0);

    // Single I fetch to 0x100, tag 3, return five cycles later.
    ic_req_valid      = 1'b1;
    ic_req_addr       = 32'h0000_0100;
    mem2proc_response = 4'd3;
    #1;
    chk("f_ready", ic_req_ready, 1'b1);
    chk("f_cmd", proc2mem_command, 2'd1);
    chk("f_addr", proc2mem_addr, 32'h100);
    chk("f_size", proc2mem_size, 2'd3);
    chk("f_data", proc2mem_data, 64'd0);
    tick();
    idle_inputs();
    chk("f_count1", outstanding_count, 4'd1);
    tick(); tick(); tick(); tick();
    mem2proc_tag  = 4'd3;
    mem2proc_data = 64'hDEADBEEF_00000013;
    tick();
    idle_inputs();
    chk("f_icv", ic_resp_valid, 1'b1);
    chk("f_icdata", ic_resp_data, 64'hDEADBEEF_00000013);
    chk("f_dcv", dc_resp_valid, 1'b0);
    chk("f_count0", outstanding_count, 4'd0);
    tick();
    chk("f_icv_off", ic_resp_valid, 1'b0);

    // Both sides load continuously: grants D, I, D, I on tags 1, 2, 4, 6.
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_0180;
    dc_req_valid = 1'b1;
    dc_req_cmd   = 2'd1;
    dc_req_addr  = 32'h0000_0200;
    mem2proc_response = 4'd1;
    #1;
    chk("arb1_dc", dc_req_ready, 1'b1);
    chk("arb1_ic", ic_req_ready, 1'b0);
    chk("arb1_addr", proc2mem_addr, 32'h200);
    tick();
    mem2proc_response = 4'd2;
    #1;
    chk("arb2_ic", ic_req_ready, 1'b1);
    chk("arb2_dc", dc_req_ready, 1'b0);
    chk("arb2_addr", proc2mem_addr, 32'h180);
    tick();
    mem2proc_response = 4'd4;
    #1;
    chk("arb3_dc", dc_req_ready, 1'b1);
    tick();
    mem2proc_response = 4'd6;
    #1;
    chk("arb4_ic", ic_req_ready, 1'b1);
    chk("arb4_dc", dc_req_ready, 1'b0);
    tick();
    chk("arb_count4", outstanding_count, 4'd4);

    // Table full: loads blocked, store still issues.
    mem2proc_response = 4'd7;
    #1;
    chk("full_ic", ic_req_ready, 1'b0);
    chk("full_dc", dc_req_ready, 1'b0);
    chk("full_cmd", proc2mem_command, 2'd0);
    dc_req_cmd  = 2'd2;
    dc_req_addr = 32'h0000_0300;
    dc_req_data = 64'h1122_3344_5566_7788;
    dc_req_size = 2'd2;
    #1;
    chk("st_ready", dc_req_ready, 1'b1);
    chk("st_cmd", proc2mem_command, 2'd2);
    chk("st_data", proc2mem_data, 64'h1122_3344_5566_7788);
    chk("st_size", proc2mem_size, 2'd2);
    chk("st_ic", ic_req_ready, 1'b0);
    tick();
    chk("st_count", outstanding_count, 4'd4);
    // Return tag 1 (D owner) frees a slot.
    dc_req_valid      = 1'b0;
    dc_req_size       = 2'd3;
    mem2proc_response = 4'd0;
    mem2proc_tag      = 4'd1;
    mem2proc_data     = 64'h0000_0000_0000_00AA;
    tick();
    mem2proc_tag = 4'd0;
    chk("ret1_dcv", dc_resp_valid, 1'b1);
    chk("ret1_dcdata", dc_resp_data, 64'hAA);
    chk("ret1_icv", ic_resp_valid, 1'b0);
    chk("ret1_count", outstanding_count, 4'd3);
    // Rejected request: selected on the bus but not ready.
    #1;
    chk("rej_cmd", proc2mem_command, 2'd1);
    chk("rej_ready", ic_req_ready, 1'b0);
    mem2proc_response = 4'd8;
    #1;
    chk("unblk_ready", ic_req_ready, 1'b1);
    tick();
    idle_inputs();
    chk("unblk_count", outstanding_count, 4'd4);

    // Drain tags 2(I), 4(D), 6(I), 8(I).
    mem2proc_tag = 4'd2;
    tick();
    chk("dr2_icv", ic_resp_valid, 1'b1);
    mem2proc_tag = 4'd4;
    tick();
    chk("dr4_dcv", dc_resp_valid, 1'b1);
    chk("dr4_icv", ic_resp_valid, 1'b0);
    mem2proc_tag = 4'd6;
    tick();
    mem2proc_tag = 4'd8;
    tick();
    mem2proc_tag = 4'd0;
    chk("dr8_icv", ic_resp_valid, 1'b1);
    chk("dr_count", outstanding_count, 4'd0);
    chk("dr_err", bus_error, 1'b0);

    // Tag 5 returned for D while reissued to I in the same cycle.
    dc_req_valid      = 1'b1;
    dc_req_cmd        = 2'd1;
    mem2proc_response = 4'd5;
    tick();
    dc_req_valid      = 1'b0;
    ic_req_valid      = 1'b1;
    mem2proc_tag      = 4'd5;
    mem2proc_data     = 64'h55;
    #1;
    chk("re5_ready", ic_req_ready, 1'b1);
    tick();
    idle_inputs();
    chk("re5_dcv", dc_resp_valid, 1'b1);
    chk("re5_dcdata", dc_resp_data, 64'h55);
    chk("re5_icv", ic_resp_valid, 1'b0);
    chk("re5_count", outstanding_count, 4'd1);
    chk("re5_err", bus_error, 1'b0);
    mem2proc_tag = 4'd5;
    tick();
    mem2proc_tag = 4'd0;
    chk("own5_icv", ic_resp_valid, 1'b1);
    chk("own5_count", outstanding_count, 4'd0);

    // Unmatched return on tag 9: sticky error, no pulse.
    mem2proc_tag = 4'd9;
    tick();
    mem2proc_tag = 4'd0;
    chk("um_err", bus_error, 1'b1);
    chk("um_icv", ic_resp_valid, 1'b0);
    chk("um_dcv", dc_resp_valid, 1'b0);
    tick(); tick();
    chk("um_sticky", bus_error, 1'b1);

    // Reset with two loads outstanding, then a stale return.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r2_err_clr", bus_error, 1'b0);
    ic_req_valid      = 1'b1;
    mem2proc_response = 4'd10;
    tick();
    ic_req_valid      = 1'b0;
    dc_req_valid      = 1'b1;
    dc_req_cmd        = 2'd1;
    mem2proc_response = 4'd11;
    tick();
    idle_inputs();
    chk("r2_count2", outstanding_count, 4'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r2_count0", outstanding_count, 4'd0);
    mem2proc_tag = 4'd10;
    tick();
    mem2proc_tag = 4'd0;
    chk("r2_err", bus_error, 1'b1);
    chk("r2_icv", ic_resp_valid, 1'b0);

    // Illegal D command: never issued, sets error.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dc_req_valid      = 1'b1;
    dc_req_cmd        = 2'd3;
    mem2proc_response = 4'd1;
    #1;
    chk("ill_ready", dc_req_ready, 1'b0);
    chk("ill_cmd", proc2mem_command, 2'd0);
    tick();
    idle_inputs();
    chk("ill_err", bus_error, 1'b1);

    // Allocation onto a live tag: error and owner overwritten to D.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ic_req_valid      = 1'b1;
    mem2proc_response = 4'd12;
    tick();
    ic_req_valid      = 1'b0;
    dc_req_valid      = 1'b1;
    dc_req_cmd        = 2'd1;
    tick();
    idle_inputs();
    chk("clash_err", bus_error, 1'b1);
    chk("clash_count", outstanding_count, 4'd1);
    mem2proc_tag  = 4'd12;
    mem2proc_data = 64'hC0FFEE;
    tick();
    mem2proc_tag = 4'd0;
    chk("clash_dcv", dc_resp_valid, 1'b1);
    chk("clash_icv", ic_resp_valid, 1'b0);
    chk("clash_dcdata", dc_resp_data, 64'hC0FFEE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
